// File: rtl/usr_n.sv
// Parametrised universal shift register with immediate ops and an
// auto-repeat sequencer that applies a shift/rotate n times then pulses done.
module usr_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] x,
    input  logic [2:0]       s,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    input  logic             rsi,
    input  logic             lsi,
    output logic [WIDTH-1:0] q,
    output logic             rso,
    output logic             lso,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SR   = 3'b001;
    localparam logic [2:0] OP_SL   = 3'b010;
    localparam logic [2:0] OP_LD   = 3'b011;
    localparam logic [2:0] OP_RR   = 3'b100;
    localparam logic [2:0] OP_RL   = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [2:0]       r_op;
    logic [2:0]       w_op_nx;
    logic             r_busy;
    logic             w_busy_nx;
    logic             r_done;
    logic             w_done_nx;
    logic             w_rep;

    function automatic logic [WIDTH-1:0] f_step(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] d,
        input logic             ri,
        input logic             li
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (op)
            OP_HOLD: r = v;
            OP_SR:   r = {ri, v[WIDTH-1:1]};
            OP_SL:   r = {v[WIDTH-2:0], li};
            OP_LD:   r = d;
            OP_RR:   r = {v[0], v[WIDTH-1:1]};
            OP_RL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_CLR:  r = '0;
            default: r = v;
        endcase
        return r;
    endfunction

    // Only shifts and rotates may be repeated; load/clear/hold fall to en.
    assign w_rep = (s == OP_SR) || (s == OP_SL) || (s == OP_RR)
                || (s == OP_RL) || (s == OP_ASR);

    always_comb begin
        w_state_nx = r_state;
        w_q_nx     = r_q;
        w_cnt_nx   = r_cnt;
        w_op_nx    = r_op;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy_nx = 1'b0;
                if (start && w_rep) begin
                    w_op_nx  = s;
                    w_cnt_nx = n;
                    if (n != '0) begin
                        w_state_nx = S_RUN;
                        w_busy_nx  = 1'b1;
                    end else begin
                        w_done_nx = 1'b1;
                    end
                end else if (en) begin
                    w_q_nx = f_step(s, r_q, x, rsi, lsi);
                end
            end
            S_RUN: begin
                w_q_nx   = f_step(r_op, r_q, x, rsi, lsi);
                w_cnt_nx = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = S_IDLE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_op    <= OP_HOLD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_q     <= w_q_nx;
            r_cnt   <= w_cnt_nx;
            r_op    <= w_op_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;
    assign rso  = r_q[0];
    assign lso  = r_q[WIDTH-1];

endmodule

// File: tb/tb_usr_n.sv
// Self-checking bench for usr_n: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_usr_n;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [W-1:0]  x = '0;
    logic [2:0]    s = '0;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] n = '0;
    logic          rsi = 1'b0;
    logic          lsi = 1'b0;
    logic [W-1:0]  q;
    logic          rso;
    logic          lso;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a pending run is just a queue of ops still to apply.
    logic [W-1:0] m_q = '0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [2:0]   pend[$];

    usr_n #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .x(x), .s(s), .en(en),
        .start(start), .n(n), .rsi(rsi), .lsi(lsi), .q(q),
        .rso(rso), .lso(lso), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic bit is_rep(input logic [2:0] op);
        return op inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    endfunction

    function automatic logic [W-1:0] f_op(input logic [2:0] op,
        input logic [W-1:0] v, input logic [W-1:0] d,
        input logic ri, input logic li);
        logic [W-1:0] r;
        int u;
        u = int'(v);
        case (op)
            3'd1: r = W'((u / 2) + (ri ? (1 << (W - 1)) : 0));
            3'd2: r = W'(((u * 2) % (1 << W)) + (li ? 1 : 0));
            3'd3: r = d;
            3'd4: r = W'((u / 2) + ((u % 2) << (W - 1)));
            3'd5: r = W'(((u * 2) % (1 << W)) + (u >> (W - 1)));
            3'd6: r = W'((u / 2) + (u & (1 << (W - 1))));
            3'd7: r = '0;
            default: r = v;
        endcase
        return r;
    endfunction

    task automatic m_reset();
        m_q = '0;
        m_busy = 1'b0;
        m_done = 1'b0;
        pend.delete();
    endtask

    task automatic m_step();
        logic [2:0] op;
        m_done = 1'b0;
        if (pend.size() > 0) begin
            op = pend.pop_front();
            m_q = f_op(op, m_q, x, rsi, lsi);
            if (pend.size() == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (start && is_rep(s)) begin
            if (n == 0) begin
                m_done = 1'b1;
            end else begin
                for (int i = 0; i < int'(n); i++) pend.push_back(s);
                m_busy = 1'b1;
            end
        end else if (en) begin
            m_q = f_op(s, m_q, x, rsi, lsi);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!resetn) m_reset();
        else m_step();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            x = W'($urandom); s = 3'($urandom); en = 1'b1;
            start = 1'($urandom); n = CW'($urandom);
            cyc();
            checks++;
            if ({q, busy, done, rso, lso} !== {{W{1'b0}}, 4'b0}) begin
                errors++;
                $display("FAIL reset_hold got %h %b%b%b%b exp 0",
                         q, busy, done, rso, lso);
            end
        end
        en = 1'b0; start = 1'b0;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s = 3'($urandom);
            cyc();
            checks++;
            if (q !== '0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_release got q=%h b=%b d=%b exp 0",
                         q, busy, done);
            end
        end
    endtask

    task automatic test_immediate();
        logic [W-1:0] exp_v[4];
        logic [2:0]   ops[4];
        exp_v = '{8'hA5, 8'hD2, 8'hA5, 8'h00};
        ops   = '{3'b011, 3'b100, 3'b101, 3'b111};
        x = 8'hA5; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = ops[i];
            cyc();
            checks++;
            if (q !== exp_v[i] || q !== m_q || busy || done) begin
                errors++;
                $display("FAIL immediate_%0d got q=%h b=%b d=%b exp %h",
                         i, q, busy, done, exp_v[i]);
            end
        end
        s = 3'b011; cyc();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = 3'($urandom); x = W'($urandom);
            cyc();
            checks++;
            if (q !== 8'hA5) begin
                errors++;
                $display("FAIL en_low_hold got %h exp a5", q);
            end
        end
    endtask

    task automatic test_shifts();
        logic [W-1:0] exp_v[3];
        logic [2:0]   ops[3];
        exp_v = '{8'hC8, 8'h64, 8'hC9};
        ops   = '{3'b110, 3'b001, 3'b010};
        x = 8'h90; s = 3'b011; en = 1'b1;
        cyc();
        rsi = 1'b0; lsi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s = ops[i];
            cyc();
            checks++;
            if (q !== exp_v[i] || rso !== exp_v[i][0]
                || lso !== exp_v[i][W-1]) begin
                errors++;
                $display("FAIL shift_%0d got q=%h rso=%b lso=%b exp %h",
                         i, q, rso, lso, exp_v[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_repeat_shift();
        logic [W-1:0] exp_v[3];
        exp_v = '{8'h80, 8'hC0, 8'hE0};
        s = 3'b111; en = 1'b1; cyc();
        en = 1'b0; s = 3'b001; n = 4'd3; rsi = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (q !== 8'h00 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rep_start got q=%h b=%b d=%b exp 00 1 0",
                     q, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            s = 3'($urandom); en = 1'($urandom); x = W'($urandom);
            cyc();
            checks++;
            if (q !== exp_v[i] || busy !== (i < 2) || done !== (i == 2)) begin
                errors++;
                $display("FAIL rep_step_%0d got q=%h b=%b d=%b exp %h",
                         i, q, busy, done, exp_v[i]);
            end
        end
        en = 1'b0; s = 3'b000;
        cyc();
        checks++;
        if (done !== 1'b0 || q !== 8'hE0) begin
            errors++;
            $display("FAIL rep_done_clear got q=%h d=%b exp e0 0", q, done);
        end
    endtask

    task automatic test_rotate_edges();
        int pulses;
        int busy_cyc;
        x = 8'hA5; s = 3'b011; en = 1'b1; cyc();
        en = 1'b0; s = 3'b101; n = 4'd8; start = 1'b1;
        cyc();
        start = 1'b0;
        pulses = 0; busy_cyc = 1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (busy) busy_cyc++;
            if (done) pulses++;
            checks++;
            if ({q, busy, done} !== {m_q, m_busy, m_done}) begin
                errors++;
                $display("FAIL rot8_model got %h%b%b exp %h%b%b",
                         q, busy, done, m_q, m_busy, m_done);
            end
        end
        checks++;
        if (q !== 8'hA5 || pulses != 1 || busy_cyc != 8) begin
            errors++;
            $display("FAIL rot8 got q=%h pulses=%0d busy=%0d exp a5 1 8",
                     q, pulses, busy_cyc);
        end
        s = 3'b100; n = 4'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (q !== 8'hA5 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL n0 got q=%h b=%b d=%b exp a5 0 1", q, busy, done);
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'hA5) begin
            errors++;
            $display("FAIL n0_after got q=%h b=%b d=%b exp a5 0 0",
                     q, busy, done);
        end
        s = 3'b011; x = 8'h3C; n = 4'd5; start = 1'b1; en = 1'b1;
        cyc();
        start = 1'b0; en = 1'b0;
        checks++;
        if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_load got q=%h b=%b d=%b exp 3c 0 0",
                     q, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        s = 3'b100; n = 4'd2; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== m_q) begin
            errors++;
            $display("FAIL b2b_first got q=%h b=%b d=%b exp %h 0 1",
                     q, busy, done, m_q);
        end
        s = 3'b010; n = 4'd3; lsi = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got b=%b d=%b exp 1 0", busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            lsi = 1'($urandom);
            cyc();
            checks++;
            if ({q, busy, done} !== {m_q, m_busy, m_done}) begin
                errors++;
                $display("FAIL b2b_run got %h%b%b exp %h%b%b",
                         q, busy, done, m_q, m_busy, m_done);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        x = 8'h5A; s = 3'b011; en = 1'b1; cyc();
        en = 1'b0; s = 3'b010; n = 4'd6; lsi = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        resetn = 1'b0;
        m_reset();
        #1;
        checks++;
        if (q !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset got q=%h b=%b d=%b exp 0 0 0",
                     q, busy, done);
        end
        cyc();
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== '0) begin
                errors++;
                $display("FAIL midrun_nodone got q=%h b=%b d=%b exp 0 0 0",
                         q, busy, done);
            end
        end
        s = 3'b001; n = 4'd2; rsi = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        checks++;
        if (q !== 8'hC0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_restart got q=%h b=%b d=%b exp c0 0 1",
                     q, busy, done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            x = W'($urandom); s = 3'($urandom); en = 1'($urandom);
            start = ($urandom_range(0, 5) == 0);
            n = CW'($urandom); rsi = 1'($urandom); lsi = 1'($urandom);
            resetn = ($urandom_range(0, 79) != 0);
            cyc();
            checks++;
            if ({q, busy, done, rso, lso}
                !== {m_q, m_busy, m_done, m_q[0], m_q[W-1]}) begin
                errors++;
                $display("FAIL random_%0d got %h%b%b%b%b exp %h%b%b%b%b",
                         i, q, busy, done, rso, lso,
                         m_q, m_busy, m_done, m_q[0], m_q[W-1]);
            end
        end
        resetn = 1'b1; start = 1'b0; en = 1'b0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_immediate();
        test_shifts();
        test_repeat_shift();
        test_rotate_edges();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
